decode_bundle_n: RTL
====================

Name: decode_bundle_n

Overview:
Parametrised N-wide decode stage; successor to the fixed two-lane decoder. Accepts a bundle of ISSUE_W 32-bit RV32I instructions per handshake and decodes each lane into register indices, immediate, ALU op and control bits. Results are registered behind a 2-entry skid buffer with valid/ready on both sides. Sits between fetch/bundle queue and rename/dispatch.

Parameters:
ISSUE_W, 2, lanes per bundle (1..8)
XLEN, 32, immediate/instruction width (fixed 32 for RV32I; checked by elaboration assert)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  bundle offered by fetch
in_ready  out  1  decode can accept bundle
in_instr  in  ISSUE_W*32  lane i at [32*i+31:32*i]
in_lane_vld  in  ISSUE_W  per-lane occupancy
out_valid  out  1  decoded bundle available
out_ready  in  1  dispatch accepts bundle
out_lane_vld  out  ISSUE_W  registered copy of in_lane_vld
out_rs1, out_rs2, out_rd  out  ISSUE_W*5 each  register indices
out_imm  out  ISSUE_W*32  sign-extended immediate
out_aluop  out  ISSUE_W*3  ALU op
out_ctrl  out  ISSUE_W*5  per lane {regWrite,aluSrc,memWrite,memRead,memtoReg}
out_illegal  out  ISSUE_W  unsupported opcode/funct in a valid lane
out_dep  out  ISSUE_W  intra-bundle RAW flag (see Optional Feature)

Behaviour:
- Reset (async assert, sync-safe deassert): all out_* fields 0, out_valid=0, in_ready=1, buffer state EMPTY.
- Decode per lane (combinational, registered on accept):
  - OP-IMM 0010011: funct3 000 ADDI aluop 000; 111 ANDI aluop 111; rs1=[19:15], rs2=0, rd=[11:7], imm=I-type sext, aluSrc=1, regWrite=1.
  - OP 0110011: ADD (f3 000,f7 0000000) aluop 000; SUB (000,0100000) 001; XOR (100,0000000) 100; SRA (101,0100000) 101; rs1,rs2,rd from fields, imm=0, aluSrc=0, regWrite=1.
  - STORE 0100011 f3 010: imm=sext({[31:25],[11:7]}) from the same lane, rd=0, aluop 000, aluSrc=1, memWrite=1.
  - LOAD 0000011 f3 010: I-type imm, aluop 000, aluSrc=1, regWrite=1, memRead=1, memtoReg=1.
  - Any other opcode/funct combination: all ctrl 0, rd=rs1=rs2=0, imm=0, aluop 000, illegal=1. No X outputs ever.
  - rd==0 forces regWrite=0 (illegal stays 0).
  - Lane with in_lane_vld=0: all fields 0, illegal=0, dep=0.
- Handshake: transfer when valid&&ready on that side. Latency 1 cycle from input accept to out_valid. out_* stable while out_valid&&!out_ready. in_ready=1 unless state FULL (registered, no combinational path from out_ready).
- Buffer FSM: EMPTY (no data), ONE (main reg valid), FULL (main+skid valid).
  - EMPTY: in accept -> ONE.
  - ONE: in accept & out accept -> ONE (main reloaded); in only -> FULL (new into skid); out only -> EMPTY.
  - FULL: in_ready=0; out accept -> ONE, skid moves to main same edge.
- Ordering strictly FIFO; no bundle dropped or duplicated.
- rst_n asserted mid-operation discards all buffered bundles immediately.

Optional Feature:
DECODE_INTRA_DEP_EN: defined -> out_dep[j]=1 when lane j valid and reads (rs1, or rs2 for OP/STORE) a nonzero rd written (regWrite=1) by any valid lane i<j in the same bundle; registered with the bundle. Undefined -> out_dep constant 0, no comparators synthesised.

Test Plan:
- Reset: rst_n=0 mid-stream with 2 bundles buffered -> out_valid=0, in_ready=1, all fields 0 within same cycle.
- ISSUE_W=2, lanes {addi x5,x1,-4 (0xFFC08293); sw x5,8(x2) (0x00512423)}, out_ready=1 -> next cycle lane0 rd=5 imm=0xFFFFFFFC aluSrc=1 regWrite=1; lane1 imm=8 memWrite=1 rd=0.
- sub x3,x4,x6 (0x406201B3) and sra x7,x8,x9 (0x409453B3) -> aluop 001 and 101; unknown 0x0000007F -> illegal=1, ctrl=0.
- Backpressure: out_ready=0 for 3 cycles, in_valid=1 -> 2 bundles accepted, in_ready=0 on third; release -> bundles emerge in order, none lost.
- Lane gating: in_lane_vld=2'b01 -> lane1 all zero; addi x0,x0,1 -> regWrite=0, illegal=0.
- With DECODE_INTRA_DEP_EN: {add x5,x1,x2; lw x6,0(x5)} -> out_dep=2'b10; without macro -> 2'b00.

Source files
------------

// File: rtl/decode_bundle_n.sv
// decode_bundle_n: ISSUE_W-lane RV32I decode stage behind a 2-entry skid buffer.
// Optional DECODE_INTRA_DEP_EN flags intra-bundle RAW hazards on out_dep.
module decode_bundle_n #(
  parameter int ISSUE_W = 2,
  parameter int XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ISSUE_W*32-1:0]   in_instr,
  input  logic [ISSUE_W-1:0]      in_lane_vld,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ISSUE_W-1:0]      out_lane_vld,
  output logic [ISSUE_W*5-1:0]    out_rs1,
  output logic [ISSUE_W*5-1:0]    out_rs2,
  output logic [ISSUE_W*5-1:0]    out_rd,
  output logic [ISSUE_W*XLEN-1:0] out_imm,
  output logic [ISSUE_W*3-1:0]    out_aluop,
  output logic [ISSUE_W*5-1:0]    out_ctrl,
  output logic [ISSUE_W-1:0]      out_illegal,
  output logic [ISSUE_W-1:0]      out_dep
);

  if (XLEN != 32) begin : g_xlen_chk
    $error("decode_bundle_n: XLEN must be 32");
  end
  if (ISSUE_W < 1 || ISSUE_W > 8) begin : g_w_chk
    $error("decode_bundle_n: ISSUE_W must be 1..8");
  end

  typedef struct packed {
    logic        vld;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  aluop;
    logic [4:0]  ctrl;
    logic        ill;
    logic        dep;
  } lane_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_e;

  function automatic lane_t dec(
    input logic [31:0] ins,
    input logic        v
  );
    lane_t      l;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_oi;
    logic       is_op;
    logic       is_sub;
    logic       is_sw;
    logic       is_lw;
    l  = '0;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    is_oi = (op == 7'b0010011) &&
            (f3 == 3'b000 || f3 == 3'b111);
    is_sub = (f3 == 3'b000) && (f7 == 7'b0100000);
    is_op = (op == 7'b0110011) && (
            (f3 == 3'b000 && f7 == 7'b0000000) ||
            is_sub ||
            (f3 == 3'b100 && f7 == 7'b0000000) ||
            (f3 == 3'b101 && f7 == 7'b0100000));
    is_sw = (op == 7'b0100011) && (f3 == 3'b010);
    is_lw = (op == 7'b0000011) && (f3 == 3'b010);
    if (v) begin
      l.vld = 1'b1;
      unique case (1'b1)
        is_oi: begin
          l.rs1   = ins[19:15];
          l.rd    = ins[11:7];
          l.imm   = {{20{ins[31]}}, ins[31:20]};
          l.aluop = f3;
          l.ctrl  = 5'b11000;
        end
        is_op: begin
          l.rs1   = ins[19:15];
          l.rs2   = ins[24:20];
          l.rd    = ins[11:7];
          l.aluop = is_sub ? 3'b001 : f3;
          l.ctrl  = 5'b10000;
        end
        is_sw: begin
          l.rs1  = ins[19:15];
          l.rs2  = ins[24:20];
          l.imm  = {{20{ins[31]}}, ins[31:25],
                    ins[11:7]};
          l.ctrl = 5'b01100;
        end
        is_lw: begin
          l.rs1  = ins[19:15];
          l.rd   = ins[11:7];
          l.imm  = {{20{ins[31]}}, ins[31:20]};
          l.ctrl = 5'b11011;
        end
        default: l.ill = 1'b1;
      endcase
      if (l.rd == 5'd0) l.ctrl[4] = 1'b0;
    end
    return l;
  endfunction

  lane_t [ISSUE_W-1:0] dec_d;
  lane_t [ISSUE_W-1:0] main_q, main_d;
  lane_t [ISSUE_W-1:0] skid_q, skid_d;
  state_e              state_q, state_d;
  logic                in_acc;
  logic                out_acc;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid && out_ready;

  // Per-lane decode plus optional older-lane RAW detection
  always_comb begin
    for (int j = 0; j < ISSUE_W; j++) begin
      dec_d[j] = dec(in_instr[32*j +: 32], in_lane_vld[j]);
    end
`ifdef DECODE_INTRA_DEP_EN
    for (int j = 1; j < ISSUE_W; j++) begin
      for (int i = 0; i < j; i++) begin
        if (dec_d[j].vld && dec_d[i].vld &&
            dec_d[i].ctrl[4] &&
            dec_d[i].rd != 5'd0 &&
            (dec_d[j].rs1 == dec_d[i].rd ||
             dec_d[j].rs2 == dec_d[i].rd)) begin
          dec_d[j].dep = 1'b1;
        end
      end
    end
`endif
  end

  // Skid buffer next state: main feeds output, skid absorbs one stall
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_acc) begin
          main_d  = dec_d;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_acc && out_acc) begin
          main_d = dec_d;
        end else if (in_acc) begin
          skid_d  = dec_d;
          state_d = FULL;
        end else if (out_acc) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_acc) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State and payload registers, async cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  for (genvar g = 0; g < ISSUE_W; g++) begin : g_out
    assign out_lane_vld[g]        = main_q[g].vld;
    assign out_rs1[5*g +: 5]      = main_q[g].rs1;
    assign out_rs2[5*g +: 5]      = main_q[g].rs2;
    assign out_rd[5*g +: 5]       = main_q[g].rd;
    assign out_imm[XLEN*g +: XLEN] = main_q[g].imm;
    assign out_aluop[3*g +: 3]    = main_q[g].aluop;
    assign out_ctrl[5*g +: 5]     = main_q[g].ctrl;
    assign out_illegal[g]         = main_q[g].ill;
    assign out_dep[g]             = main_q[g].dep;
  end

endmodule
